// File: rtl/dsi_dist_pkg.sv
// Shared types and helpers for the DSI lane distributor.
// Optional byte counter in the top is enabled by DSI_DIST_BYTE_CNT_EN.
package dsi_dist_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } dist_state_t;

    // Strobes wider than 32 bits are not supported.
    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dsi_word_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module dsi_word_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dsi_lane_distributor.sv
// Spreads packet bytes from a word stream across 1..LANES_MAX DSI data lanes.
// Define DSI_DIST_BYTE_CNT_EN to add the per-packet byte_count output.
module dsi_lane_distributor
    import dsi_dist_pkg::*;
#(
    parameter  int LANES_MAX  = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int BYTES_IN   = 4,
    localparam int LN_W       = (LANES_MAX > 1) ? $clog2(LANES_MAX) : 1
) (
    input  logic                        clk_sys,
    input  logic                        rst,
    input  logic [BYTE_W*BYTES_IN-1:0]  in_data,
    input  logic [BYTES_IN-1:0]         in_strb,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LN_W-1:0]             lanes_number,
    input  logic                        lanes_data_rqst,
    output logic [BYTE_W*LANES_MAX-1:0] out_data,
    output logic [LANES_MAX-1:0]        out_valid,
    output logic [LANES_MAX-1:0]        out_last,
    output logic                        busy,
    output logic                        underflow_error,
    input  logic                        clear_error
`ifdef DSI_DIST_BYTE_CNT_EN
    ,
    output logic [15:0]                 byte_count
`endif
);

    localparam int ACC_BYTES = BYTES_IN + LANES_MAX - 1;
    localparam int CNT_W     = $clog2(ACC_BYTES + 1);
    localparam int N_W       = $clog2(LANES_MAX + 1);
    localparam int FW        = BYTE_W*BYTES_IN + BYTES_IN + 1;

    dist_state_t                 state_reg, state_next;
    logic [BYTE_W-1:0]           acc_reg    [ACC_BYTES];
    logic [BYTE_W-1:0]           acc_next   [ACC_BYTES];
    logic [BYTE_W-1:0]           comb_bytes [ACC_BYTES];
    logic [CNT_W-1:0]            acc_cnt_reg, acc_cnt_next;
    logic                        last_popped_reg, last_popped_next;
    logic [N_W-1:0]              lanes_reg, lanes_next, lanes_in;
    logic                        nxt_started_reg, nxt_started_next;
    logic                        nxt_last_reg, nxt_last_next;
    logic [N_W-1:0]              nxt_lanes_reg, nxt_lanes_next;
    logic                        err_reg;
    logic [BYTE_W*LANES_MAX-1:0] out_data_reg, out_data_next;
    logic [LANES_MAX-1:0]        out_valid_reg, out_valid_next;
    logic [LANES_MAX-1:0]        out_last_reg, out_last_next;

    logic                        fifo_full, fifo_empty, pop, accept, pkt_start;
    logic                        last_in, do_beat, do_final, do_uflow;
    logic [FW-1:0]               fifo_rd;
    logic [BYTE_W*BYTES_IN-1:0]  f_data;
    logic [BYTES_IN-1:0]         f_strb;
    logic                        f_last;
    int                          total, consume, n_int;

    // A word moves into the accumulator only when it fits whole; words of a
    // following packet stay queued until the current packet's last beat.
    assign pop      = !fifo_empty && !last_popped_reg
                      && (int'(acc_cnt_reg) + BYTES_IN <= ACC_BYTES);
    assign in_ready = !rst && !(state_reg == ST_DRAIN && nxt_last_reg)
                      && (!fifo_full || pop);
    assign accept   = in_valid && in_ready;
    assign {f_last, f_strb, f_data} = fifo_rd;

    dsi_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst     (rst),
        .push    (accept),
        .wr_data ({in_last, in_strb, in_data}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        lanes_in = N_W'(LANES_MAX);
        if (int'(lanes_number) < LANES_MAX) begin
            lanes_in = N_W'(int'(lanes_number) + 1);
        end
    end

    // Accumulator contents merged with the word being popped this cycle, so
    // freshly popped bytes are usable without an extra cycle of latency.
    always_comb begin
        total = int'(acc_cnt_reg);
        for (int j = 0; j < ACC_BYTES; j++) begin
            comb_bytes[j] = acc_reg[j];
            if (pop && j >= int'(acc_cnt_reg) && j < int'(acc_cnt_reg) + BYTES_IN) begin
                comb_bytes[j] = f_data[BYTE_W*(j - int'(acc_cnt_reg)) +: BYTE_W];
            end
        end
        if (pop) begin
            total = total + popcount(32'(f_strb));
        end
        n_int    = int'(lanes_reg);
        last_in  = last_popped_reg || (pop && f_last);
        do_final = lanes_data_rqst && (state_reg == ST_DRAIN) && last_in && (total <= n_int);
        do_beat  = lanes_data_rqst && (state_reg != ST_IDLE) && !do_final && (total >= n_int);
        do_uflow = lanes_data_rqst && (state_reg == ST_ACTIVE) && (total < n_int);
        consume  = do_final ? total : (do_beat ? n_int : 0);
        for (int j = 0; j < ACC_BYTES; j++) begin
            acc_next[j] = (j + consume < ACC_BYTES) ? comb_bytes[j + consume] : '0;
        end
        acc_cnt_next     = CNT_W'(total - consume);
        last_popped_next = last_in && !do_final;
    end

    genvar gi;
    for (gi = 0; gi < LANES_MAX; gi++) begin : g_lane
        assign out_valid_next[gi]                  = (gi < consume);
        assign out_data_next[BYTE_W*gi +: BYTE_W]  = (gi < consume) ? comb_bytes[gi] : '0;
        assign out_last_next[gi]                   = do_final && (gi < n_int);
    end

    always_comb begin
        state_next       = state_reg;
        lanes_next       = lanes_reg;
        nxt_started_next = nxt_started_reg;
        nxt_last_next    = nxt_last_reg;
        nxt_lanes_next   = nxt_lanes_reg;
        pkt_start        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = in_last ? ST_DRAIN : ST_ACTIVE;
                    lanes_next = lanes_in;
                    pkt_start  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (accept && in_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Words accepted while draining open the next packet.
                if (accept && !nxt_started_reg) begin
                    nxt_started_next = 1'b1;
                    nxt_lanes_next   = lanes_in;
                end
                if (accept && in_last) begin
                    nxt_last_next = 1'b1;
                end
                if (do_final) begin
                    nxt_started_next = 1'b0;
                    nxt_last_next    = 1'b0;
                    if (nxt_started_reg || accept) begin
                        pkt_start  = 1'b1;
                        lanes_next = nxt_started_reg ? nxt_lanes_reg : lanes_in;
                        state_next = (nxt_last_reg || (accept && in_last)) ? ST_DRAIN : ST_ACTIVE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            acc_cnt_reg     <= '0;
            last_popped_reg <= 1'b0;
            lanes_reg       <= '0;
            nxt_started_reg <= 1'b0;
            nxt_last_reg    <= 1'b0;
            nxt_lanes_reg   <= '0;
            err_reg         <= 1'b0;
            out_data_reg    <= '0;
            out_valid_reg   <= '0;
            out_last_reg    <= '0;
            for (int j = 0; j < ACC_BYTES; j++) begin
                acc_reg[j] <= '0;
            end
        end else begin
            state_reg       <= state_next;
            acc_cnt_reg     <= acc_cnt_next;
            last_popped_reg <= last_popped_next;
            lanes_reg       <= lanes_next;
            nxt_started_reg <= nxt_started_next;
            nxt_last_reg    <= nxt_last_next;
            nxt_lanes_reg   <= nxt_lanes_next;
            err_reg         <= do_uflow ? 1'b1 : (clear_error ? 1'b0 : err_reg);
            out_data_reg    <= out_data_next;
            out_valid_reg   <= out_valid_next;
            out_last_reg    <= out_last_next;
            for (int j = 0; j < ACC_BYTES; j++) begin
                acc_reg[j] <= acc_next[j];
            end
        end
    end

    assign out_data        = out_data_reg;
    assign out_valid       = out_valid_reg;
    assign out_last        = out_last_reg;
    assign busy            = (state_reg != ST_IDLE);
    assign underflow_error = err_reg;

`ifdef DSI_DIST_BYTE_CNT_EN
    logic [15:0] byte_cnt_reg;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            byte_cnt_reg <= '0;
        end else if (pkt_start) begin
            byte_cnt_reg <= '0;
        end else begin
            byte_cnt_reg <= byte_cnt_reg + 16'(consume);
        end
    end

    assign byte_count = byte_cnt_reg;
`endif

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Directed, table-driven bench for dsi_lane_distributor (default parameters).
module tb_dsi_lane_distributor;

    localparam int LANES_MAX  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BYTES_IN   = 4;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  lanes_number;
    logic        lanes_data_rqst;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_last;
    logic        busy;
    logic        underflow_error;
    logic        clear_error;
`ifdef DSI_DIST_BYTE_CNT_EN
    logic [15:0] byte_count;
`endif

    always #5 clk_sys = ~clk_sys;

    dsi_lane_distributor #(
        .LANES_MAX  (LANES_MAX),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BYTES_IN   (BYTES_IN)
    ) dut (
        .clk_sys         (clk_sys),
        .rst             (rst),
        .in_data         (in_data),
        .in_strb         (in_strb),
        .in_last         (in_last),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .lanes_number    (lanes_number),
        .lanes_data_rqst (lanes_data_rqst),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .busy            (busy),
        .underflow_error (underflow_error),
        .clear_error     (clear_error)
`ifdef DSI_DIST_BYTE_CNT_EN
        ,
        .byte_count      (byte_count)
`endif
    );

    typedef struct packed {
        logic [1:0]       lanes_number;
        logic [1:0]       nwords;
        logic [2:0][31:0] data;
        logic [2:0][3:0]  strb;
        logic [1:0]       nbeats;
        logic [2:0][31:0] exp_data;
        logic [2:0][3:0]  exp_valid;
        logic [2:0][3:0]  exp_last;
    } vec_t;

    vec_t vecs [6];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkword(input logic [7:0] b0);
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    task automatic idle_inputs;
        in_data = '0; in_strb = '0; in_last = 1'b0; in_valid = 1'b0;
        lanes_number = '0; lanes_data_rqst = 1'b0; clear_error = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nbytes;
        nbytes = 0;
        lanes_number = v.lanes_number;
        for (int w = 0; w < int'(v.nwords); w++) begin
            in_data  = v.data[w];
            in_strb  = v.strb[w];
            in_last  = (w == int'(v.nwords) - 1);
            in_valid = 1'b1;
            nbytes  += $countones(v.strb[w]);
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            tick;
            lanes_number = ~v.lanes_number;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("vec_busy", 64'(busy), 64'd1);
        repeat (3) tick;
        lanes_data_rqst = 1'b1;
        for (int b = 0; b < int'(v.nbeats); b++) begin
            tick;
            chk("vec_data",  64'(out_data),  64'(v.exp_data[b]));
            chk("vec_valid", 64'(out_valid), 64'(v.exp_valid[b]));
            chk("vec_last",  64'(out_last),  64'(v.exp_last[b]));
        end
        lanes_data_rqst = 1'b0;
        tick;
        chk("vec_idle_valid", 64'(out_valid), 64'd0);
        chk("vec_idle_data",  64'(out_data),  64'd0);
        chk("vec_idle_last",  64'(out_last),  64'd0);
        chk("vec_busy_end",   64'(busy),      64'd0);
        chk("vec_no_uflow",   64'(underflow_error), 64'd0);
`ifdef DSI_DIST_BYTE_CNT_EN
        chk("vec_byte_count", 64'(byte_count), 64'(nbytes));
`endif
        $display("vector %0d: lanes=%0d words=%0d beats=%0d bytes=%0d", idx,
                 int'(v.lanes_number) + 1, v.nwords, v.nbeats, nbytes);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;

        // 4 lanes, 12 bytes in 3 full words
        vecs[0].lanes_number = 2'd3; vecs[0].nwords = 2'd3;
        vecs[0].data      = {32'h0B0A0908, 32'h07060504, 32'h03020100};
        vecs[0].strb      = {4'hF, 4'hF, 4'hF};
        vecs[0].nbeats    = 2'd3;
        vecs[0].exp_data  = {32'h0B0A0908, 32'h07060504, 32'h03020100};
        vecs[0].exp_valid = {4'hF, 4'hF, 4'hF};
        vecs[0].exp_last  = {4'hF, 4'h0, 4'h0};
        // 3 lanes, 6 bytes, partial last strobe
        vecs[1].lanes_number = 2'd2; vecs[1].nwords = 2'd2;
        vecs[1].data      = {32'h0, 32'h00000504, 32'h03020100};
        vecs[1].strb      = {4'h0, 4'h3, 4'hF};
        vecs[1].nbeats    = 2'd2;
        vecs[1].exp_data  = {32'h0, 32'h00050403, 32'h00020100};
        vecs[1].exp_valid = {4'h0, 4'h7, 4'h7};
        vecs[1].exp_last  = {4'h0, 4'h7, 4'h0};
        // 4 lanes, 5 bytes: short final beat
        vecs[2].lanes_number = 2'd3; vecs[2].nwords = 2'd2;
        vecs[2].data      = {32'h0, 32'hEEEEEE04, 32'h03020100};
        vecs[2].strb      = {4'h0, 4'h1, 4'hF};
        vecs[2].nbeats    = 2'd2;
        vecs[2].exp_data  = {32'h0, 32'h00000004, 32'h03020100};
        vecs[2].exp_valid = {4'h0, 4'h1, 4'hF};
        vecs[2].exp_last  = {4'h0, 4'hF, 4'h0};
        // 1 lane, 2 bytes in a single last word
        vecs[3].lanes_number = 2'd0; vecs[3].nwords = 2'd1;
        vecs[3].data      = {32'h0, 32'h0, 32'h0000BBAA};
        vecs[3].strb      = {4'h0, 4'h0, 4'h3};
        vecs[3].nbeats    = 2'd2;
        vecs[3].exp_data  = {32'h0, 32'h000000BB, 32'h000000AA};
        vecs[3].exp_valid = {4'h0, 4'h1, 4'h1};
        vecs[3].exp_last  = {4'h0, 4'h1, 4'h0};
        // 4 lanes, empty packet (zero strobe with last)
        vecs[4].lanes_number = 2'd3; vecs[4].nwords = 2'd1;
        vecs[4].data      = {32'h0, 32'h0, 32'hDEADBEEF};
        vecs[4].strb      = {4'h0, 4'h0, 4'h0};
        vecs[4].nbeats    = 2'd1;
        vecs[4].exp_data  = {32'h0, 32'h0, 32'h0};
        vecs[4].exp_valid = {4'h0, 4'h0, 4'h0};
        vecs[4].exp_last  = {4'h0, 4'h0, 4'hF};
        // 2 lanes, 3 bytes
        vecs[5].lanes_number = 2'd1; vecs[5].nwords = 2'd1;
        vecs[5].data      = {32'h0, 32'h0, 32'h77332211};
        vecs[5].strb      = {4'h0, 4'h0, 4'h7};
        vecs[5].nbeats    = 2'd2;
        vecs[5].exp_data  = {32'h0, 32'h00000033, 32'h00002211};
        vecs[5].exp_valid = {4'h0, 4'h1, 4'h3};
        vecs[5].exp_last  = {4'h0, 4'h3, 4'h0};

        idle_inputs();
        rst = 1'b1;
        tick;
        tick;
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_uflow",     64'(underflow_error), 64'd0);
`ifdef DSI_DIST_BYTE_CNT_EN
        chk("rst_byte_count", 64'(byte_count), 64'd0);
`endif
        rst = 1'b0;
        tick;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // request while idle is ignored
        lanes_data_rqst = 1'b1;
        tick;
        lanes_data_rqst = 1'b0;
        chk("idle_rqst_valid", 64'(out_valid), 64'd0);
        chk("idle_rqst_uflow", 64'(underflow_error), 64'd0);
        chk("idle_rqst_busy",  64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // underflow: sticky, clearable, set beats clear
        lanes_number = 2'd3;
        in_data = 32'h13121110; in_strb = 4'hF; in_last = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (2) tick;
        lanes_data_rqst = 1'b1;
        tick;
        chk("uf_beat_data", 64'(out_data), 64'h13121110);
        tick;
        chk("uf_flag",  64'(underflow_error), 64'd1);
        chk("uf_valid", 64'(out_valid), 64'd0);
        lanes_data_rqst = 1'b0; clear_error = 1'b1;
        tick;
        chk("uf_cleared", 64'(underflow_error), 64'd0);
        lanes_data_rqst = 1'b1; clear_error = 1'b1;
        tick;
        chk("uf_set_wins", 64'(underflow_error), 64'd1);
        lanes_data_rqst = 1'b0; clear_error = 1'b0;
        tick;
        chk("uf_sticky", 64'(underflow_error), 64'd1);
        in_strb = 4'h0; in_last = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        tick;
        lanes_data_rqst = 1'b1;
        tick;
        chk("uf_close_last",  64'(out_last),  64'hF);
        chk("uf_close_valid", 64'(out_valid), 64'h0);
        lanes_data_rqst = 1'b0; clear_error = 1'b1;
        tick;
        clear_error = 1'b0;
        chk("uf_close_busy", 64'(busy), 64'd0);
        $display("underflow sequence done");

        // back-pressure: FIFO plus one accumulator-resident word fill up
        lanes_number = 2'd3; in_strb = 4'hF; in_last = 1'b0; in_valid = 1'b1;
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            in_data = mkword(8'(64 + 4*accepted));
            if (!in_ready) break;
            tick;
            accepted++;
        end
        chk("ff_accepted", 64'(accepted), 64'(FIFO_DEPTH + 1));
        in_data = mkword(8'(64 + 4*(FIFO_DEPTH + 1)));
        in_last = 1'b1;
        tick;
        tick;
        chk("ff_ready_held", 64'(in_ready), 64'd0);
        lanes_data_rqst = 1'b1;
        tick;
        lanes_data_rqst = 1'b0;
        chk("ff_beat1_data", 64'(out_data), 64'(mkword(8'd64)));
        chk("ff_ready_back", 64'(in_ready), 64'd1);
        tick;
        in_valid = 1'b0; in_last = 1'b0;
        lanes_data_rqst = 1'b1;
        for (int b = 1; b <= FIFO_DEPTH + 1; b++) begin
            tick;
            chk("ff_beat_data",  64'(out_data),  64'(mkword(8'(64 + 4*b))));
            chk("ff_beat_valid", 64'(out_valid), 64'hF);
            chk("ff_beat_last",  64'(out_last),  (b == FIFO_DEPTH + 1) ? 64'hF : 64'h0);
        end
        lanes_data_rqst = 1'b0;
        tick;
        chk("ff_busy_end", 64'(busy), 64'd0);
        $display("back-pressure sequence done: %0d words held", accepted);

        // reset mid-packet
        lanes_number = 2'd3; in_strb = 4'hF; in_last = 1'b0; in_valid = 1'b1;
        in_data = mkword(8'h80);
        tick;
        in_data = mkword(8'h84);
        tick;
        in_valid = 1'b0;
        repeat (2) tick;
        lanes_data_rqst = 1'b1;
        tick;
        lanes_data_rqst = 1'b0;
        chk("mr_beat_data", 64'(out_data), 64'(mkword(8'h80)));
        rst = 1'b1;
        tick;
        chk("mr_valid",    64'(out_valid), 64'd0);
        chk("mr_data",     64'(out_data),  64'd0);
        chk("mr_last",     64'(out_last),  64'd0);
        chk("mr_busy",     64'(busy),      64'd0);
        chk("mr_in_ready", 64'(in_ready),  64'd0);
`ifdef DSI_DIST_BYTE_CNT_EN
        chk("mr_byte_count", 64'(byte_count), 64'd0);
`endif
        rst = 1'b0;
        tick;
        $display("reset mid-packet applied");
        run_vec(6, vecs[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
